// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: oversampling monitor for the LCD SPI bus; rebuilds {dc,byte} words
// and decodes the ST7789 CASET/RASET/RAMWR commands into addressed RGB565 pixel writes.
`timescale 1ns/1ps
module lcd_spi_rx #(
  parameter logic [8:0] MAX_X = 9'd239,
  parameter logic [8:0] MAX_Y = 9'd319
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst,
  input  logic        lcd_cs,
  input  logic        lcd_dc,
  input  logic        lcd_sclk,
  input  logic        lcd_mosi,
  output logic [8:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] pix_data,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid
);
  typedef enum logic [1:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR} state_t;
  logic r_cs_m, r_cs_s, r_cs_q, r_dc_m, r_dc_s, r_sclk_m, r_sclk_s, r_sclk_q, r_mosi_m, r_mosi_s;
  logic [2:0] r_cnt;
  logic [7:0] r_sr;
  logic r_done;
  logic [8:0] r_word;
  logic w_rise, w_shift, w_cs_rise;
  logic [2:0] w_cnt_n;
  state_t r_state, w_state_n;
  logic [2:0] r_pcnt;
  logic r_p0, r_p2, r_phase;
  logic [7:0] r_p1, r_hi;
  logic [8:0] r_xs, r_xe, r_ys, r_ye, r_cur_x, r_cur_y;
  logic w_cmd, w_dat, w_win, w_pix, w_xwrap;
  logic [7:0] w_byte;
  logic [8:0] w_start, w_end;
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      {r_cs_m, r_cs_s, r_cs_q} <= 3'b111;
      {r_dc_m, r_dc_s, r_sclk_m, r_sclk_s, r_sclk_q, r_mosi_m, r_mosi_s} <= '0;
    end else begin
      {r_cs_m, r_cs_s, r_cs_q} <= {lcd_cs, r_cs_m, r_cs_s};
      {r_dc_m, r_dc_s} <= {lcd_dc, r_dc_m};
      {r_sclk_m, r_sclk_s, r_sclk_q} <= {lcd_sclk, r_sclk_m, r_sclk_s};
      {r_mosi_m, r_mosi_s} <= {lcd_mosi, r_mosi_m};
    end
  end
  // a rise landing in the same cycle as the CS rise still counts, so the byte can complete
  assign w_rise    = r_sclk_s & ~r_sclk_q;
  assign w_shift   = w_rise & ~(r_cs_s & r_cs_q);
  assign w_cs_rise = r_cs_s & ~r_cs_q;
  assign w_cnt_n   = w_shift ? r_cnt + 3'd1 : r_cnt;
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      r_cnt <= '0;
      r_sr <= '0;
      r_done <= 1'b0;
      r_word <= '0;
      frame_err <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
    end else begin
      r_cnt <= r_cs_s ? 3'd0 : w_cnt_n;
      r_sr <= w_shift ? {r_sr[6:0], r_mosi_s} : r_sr;
      r_done <= w_shift & (r_cnt == 3'd7);
      if (w_shift & (r_cnt == 3'd7)) r_word <= {r_dc_s, r_sr[6:0], r_mosi_s};
      frame_err <= w_cs_rise & (w_cnt_n != 3'd0);
      rx_valid <= r_done;
      if (r_done) rx_data <= r_word;
    end
  end
  assign w_cmd   = rx_valid & ~rx_data[8];
  assign w_dat   = rx_valid & rx_data[8];
  assign w_byte  = rx_data[7:0];
  assign w_win   = (r_state == S_CASET) | (r_state == S_RASET);
  assign w_pix   = w_dat & (r_state == S_RAMWR) & r_phase;
  assign w_xwrap = r_cur_x == r_xe;
  assign w_start = {r_p0, r_p1};
  assign w_end   = {r_p2, w_byte};
  always_comb begin
    w_state_n = r_state;
    if (w_cmd)
      w_state_n = w_byte == 8'h2A ? S_CASET :
                  w_byte == 8'h2B ? S_RASET :
                  w_byte == 8'h2C ? S_RAMWR : S_IDLE;
  end
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) r_state <= S_IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      r_pcnt <= '0;
      {r_p0, r_p1, r_p2} <= '0;
      r_xs <= '0;
      r_xe <= MAX_X;
      r_ys <= '0;
      r_ye <= MAX_Y;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_phase <= 1'b0;
      r_hi <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      pix_valid <= w_pix;
      if (w_cmd) begin
        r_pcnt <= '0;
        r_phase <= 1'b0;
        r_cur_x <= r_xs;
        r_cur_y <= r_ys;
      end else if (w_dat & w_win & (r_pcnt != 3'd4)) begin
        r_pcnt <= r_pcnt + 3'd1;
        if (r_pcnt == 3'd0) r_p0 <= w_byte[0];
        if (r_pcnt == 3'd1) r_p1 <= w_byte;
        if (r_pcnt == 3'd2) r_p2 <= w_byte[0];
        if (r_pcnt == 3'd3 && r_state == S_CASET) {r_xs, r_xe} <= {w_start, w_end};
        if (r_pcnt == 3'd3 && r_state == S_RASET) {r_ys, r_ye} <= {w_start, w_end};
      end else if (w_dat & (r_state == S_RAMWR)) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= w_byte;
        if (r_phase) begin
          pix_data <= {r_hi, w_byte};
          pix_x <= r_cur_x;
          pix_y <= r_cur_y;
          r_cur_x <= w_xwrap ? r_xs : r_cur_x + 9'd1;
          r_cur_y <= !w_xwrap ? r_cur_y : r_cur_y == r_ye ? r_ys : r_cur_y + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed bus transactions at 5 MHz SCLK against hand-computed words and pixels.
`timescale 1ns/1ps
module tb_lcd_spi_rx;
  logic clk = 1'b0, rst = 1'b1;
  logic lcd_cs = 1'b1, lcd_dc = 1'b0, lcd_sclk = 1'b0, lcd_mosi = 1'b0;
  logic [8:0] rx_data, pix_x, pix_y;
  logic rx_valid, frame_err, pix_valid;
  logic [15:0] pix_data;
  int n_chk = 0, n_fail = 0;
  int n_rx = 0, n_ferr = 0;
  logic [8:0] last_rx = '0;
  logic [15:0] pq_d[$];
  logic [8:0] pq_x[$], pq_y[$];
  int base_rx, base_ferr, base_pix;
  lcd_spi_rx dut (
    .sys_clk_50MHz(clk), .sys_rst(rst), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      last_rx = rx_data;
    end
    if (frame_err) n_ferr++;
    if (pix_valid) begin
      pq_d.push_back(pix_data);
      pq_x.push_back(pix_x);
      pq_y.push_back(pix_y);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bit_out(input logic d, input logic b);
    lcd_dc = d;
    lcd_mosi = b;
    #100 lcd_sclk = 1'b1;
    #100 lcd_sclk = 1'b0;
  endtask
  task automatic send(input logic d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_out(d, b[i]);
  endtask
  task automatic cs_lo();
    lcd_cs = 1'b0;
    #100;
  endtask
  task automatic cs_hi();
    #100 lcd_cs = 1'b1;
    #300;
  endtask
  task automatic chk_pix(input string tag, input int idx, input logic [15:0] d, input logic [8:0] x, input logic [8:0] y);
    if (idx >= pq_d.size()) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk({tag, "_data"}, pq_d[idx], d);
      chk({tag, "_x"}, pq_x[idx], x);
      chk({tag, "_y"}, pq_y[idx], y);
    end
  endtask
  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    cs_lo();
    send(1'b0, 8'hA5);
    cs_hi();
    chk("single_count", n_rx, 1);
    chk("single_data", last_rx, 9'h0A5);
    chk("single_ferr", n_ferr, 0);
    base_pix = pq_d.size();
    cs_lo();
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0B);
    send(1'b0, 8'h2B);
    send(1'b1, 8'h00); send(1'b1, 8'h14); send(1'b1, 8'h00); send(1'b1, 8'h15);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hF8); send(1'b1, 8'h00); send(1'b1, 8'h07); send(1'b1, 8'hE0);
    send(1'b1, 8'h00); send(1'b1, 8'h1F); send(1'b1, 8'hFF); send(1'b1, 8'hFF);
    send(1'b1, 8'h12); send(1'b1, 8'h34);
    send(1'b0, 8'h00);
    cs_hi();
    chk("win_pix_count", pq_d.size() - base_pix, 5);
    chk_pix("win_p0", base_pix, 16'hF800, 9'd10, 9'd20);
    chk_pix("win_p1", base_pix + 1, 16'h07E0, 9'd11, 9'd20);
    chk_pix("win_p2", base_pix + 2, 16'h001F, 9'd10, 9'd21);
    chk_pix("win_p3", base_pix + 3, 16'hFFFF, 9'd11, 9'd21);
    chk_pix("win_p4_wrap", base_pix + 4, 16'h1234, 9'd10, 9'd20);
    chk("win_ferr", n_ferr, 0);
    base_rx = n_rx;
    cs_lo();
    for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b1);
    cs_hi();
    chk("trunc_ferr", n_ferr, 1);
    chk("trunc_no_rx", n_rx - base_rx, 0);
    cs_lo();
    send(1'b1, 8'h3C);
    cs_hi();
    chk("trunc_next_count", n_rx - base_rx, 1);
    chk("trunc_next_data", last_rx, 9'h13C);
    chk("trunc_next_ferr", n_ferr, 1);
    base_ferr = n_ferr;
    cs_lo();
    send(1'b0, 8'h2C);
    send(1'b1, 8'h99);
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b1);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_rx_data", rx_data, 0);
    chk("rstmid_rx_valid", rx_valid, 0);
    chk("rstmid_pix_data", pix_data, 0);
    chk("rstmid_pix_x", pix_x, 0);
    chk("rstmid_pix_y", pix_y, 0);
    chk("rstmid_pix_valid", pix_valid, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cs_hi();
    chk("rstmid_no_ferr", n_ferr - base_ferr, 0);
    base_pix = pq_d.size();
    cs_lo();
    send(1'b0, 8'h2C);
    send(1'b1, 8'h5A); send(1'b1, 8'h5A);
    cs_hi();
    chk("rstmid_pix_count", pq_d.size() - base_pix, 1);
    chk_pix("rstmid_pix", base_pix, 16'h5A5A, 9'd0, 9'd0);
    base_pix = pq_d.size();
    cs_lo();
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); send(1'b1, 8'h05);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h0F); send(1'b1, 8'h0F);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hEE);
    send(1'b0, 8'h00);
    send(1'b1, 8'h11); send(1'b1, 8'h22);
    cs_hi();
    chk("partial_pix_count", pq_d.size() - base_pix, 1);
    chk_pix("partial_pix", base_pix, 16'h0F0F, 9'd0, 9'd0);
    base_pix = pq_d.size();
    cs_lo();
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAA); send(1'b1, 8'hBB); send(1'b1, 8'hCC);
    cs_hi();
    chk("split_first_count", pq_d.size() - base_pix, 1);
    cs_lo();
    send(1'b1, 8'hDD);
    cs_hi();
    chk("split_total_count", pq_d.size() - base_pix, 2);
    chk_pix("split_p0", base_pix, 16'hAABB, 9'd0, 9'd0);
    chk_pix("split_p1", base_pix + 1, 16'hCCDD, 9'd1, 9'd0);
    chk("split_ferr", n_ferr - base_ferr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

Receive-side monitor for the 4-wire LCD SPI bus (CS, DC, SCLK, MOSI) driven by the LCD write path. It oversamples the bus in the system clock domain and rebuilds each transferred byte as a 9-bit `{dc, byte}` word, the same format the write path consumes. It also decodes the ST7789 window and RAM-write commands into addressed RGB565 pixel writes. It sits beside the LCD pins as a bus checker in simulation and as a frame-capture source for an on-chip shadow framebuffer.

## Interface
- `MAX_X`, default 239: reset value of the window X end.
- `MAX_Y`, default 319: reset value of the window Y end.
- `sys_clk_50MHz`  in  1  system clock; the only clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `lcd_cs`  in  1  bus chip select, active low; asynchronous to the clock.
- `lcd_dc`  in  1  0 = command, 1 = data.
- `lcd_sclk`  in  1  SPI clock, mode 0. Data is sampled on the rising edge.
- `lcd_mosi`  in  1  serial data, MSB first.
- `rx_data`  out  9  last received word, `{dc, byte[7:0]}`.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is new this cycle.
- `frame_err`  out  1  one-cycle strobe; CS deasserted mid-byte.
- `pix_data`  out  16  RGB565 pixel, `{first byte, second byte}`.
- `pix_x`, `pix_y`  out  9 each  pixel coordinate.
- `pix_valid`  out  1  one-cycle strobe; `pix_*` are valid.

## Operation
- **Input synchronisation:** each of the four bus inputs passes through 2 flops, giving `cs_s`, `dc_s`, `sclk_s`, `mosi_s`. The rising-edge detector is `sclk_s & ~sclk_q`.
- **Shifter:**
  - While `cs_s`=0, each SCLK rise shifts `mosi_s` into an 8-bit register and increments a 3-bit counter.
  - When the counter wraps from 7 to 0, `rx_data <= {dc_s, shifted byte}` and `rx_valid` pulses.
  - `dc_s` is taken at the 8th rise.
- **CS deassertion:** `cs_s`=1 holds the counter at 0 and ignores SCLK. If `cs_s` rises while the counter is non-zero, `frame_err` pulses and the partial byte is discarded.
- **Decoder FSM** advances only on `rx_valid`. States: IDLE, CASET, RASET, RAMWR.
  - Any command word (dc=0) leaves the current state, even mid-parameter.
  - 0x2A → CASET; 0x2B → RASET; 0x2C → RAMWR; any other command → IDLE.
  - Data words in IDLE are ignored.
- **CASET / RASET:**
  - Collect 4 parameter bytes P0..P3. Start = `{P0,P1}[8:0]`, end = `{P2,P3}[8:0]`.
  - Bits 15:9 are ignored.
  - The window registers (`xs`, `xe` or `ys`, `ye`) are committed only on P3. A partial parameter set is discarded.
  - Bytes after P3 are ignored until the next command.
- **RAMWR:**
  - Entry sets `cur_x=xs`, `cur_y=ys`, byte phase 0.
  - Phase 0 stores the high byte. Phase 1 emits `pix_valid` with `pix_data={hi,lo}`, `pix_x=cur_x`, `pix_y=cur_y`, then advances the address:
    - if `cur_x==xe`: `cur_x=xs`, and `cur_y` becomes `ys` if `cur_y==ye`, else `cur_y+1`;
    - otherwise `cur_x+1`.
  - 9-bit arithmetic. A window with `xs>xe` still wraps only on equality; 9-bit overflow wraps to 0.
- **CS and decoder state:** CS toggling does not change FSM state, window, address or byte phase. A RAMWR stream may span several CS frames.
- **Reset values:**
  - All outputs are 0; counters and FSM go to IDLE.
  - `xs=0`, `xe=MAX_X`, `ys=0`, `ye=MAX_Y`.
  - Synchroniser flops reset to `cs=1` and all others 0, so no edge is seen at reset release.
- **Reset during a transfer:** the partial byte is dropped without `frame_err`. Decoding restarts cleanly at the next CS low.

## Timing
- **SCLK rate:** the high and low phases must each be ≥ 2 `sys_clk_50MHz` cycles, i.e. SCLK ≤ 12.5 MHz. Faster SCLK is unsupported.
- **DC, MOSI setup:** DC and MOSI must be stable ≥ 2 cycles before the SCLK rise.
- **`rx_valid` latency:** `rx_valid` asserts 4 cycles after the first clock edge that samples `lcd_sclk`=1 for bit 7. That is 2 synchroniser cycles, 1 edge-detect cycle and 1 output-register cycle.
- **`pix_valid` latency:** `pix_valid` asserts 1 cycle after the `rx_valid` of the pixel low byte.
- **Window update:** a window committed by a P3 `rx_valid` is in effect in the next cycle.
- **`frame_err` latency:** `frame_err` asserts 3 cycles after the clock edge that first samples `lcd_cs`=1.
- **Strobe widths:** every strobe is exactly 1 cycle wide. At most one `rx_valid` occurs per 4 cycles.
- **Simultaneous events:** if the 8th SCLK rise and the CS rise land in the same synchronised cycle, the byte completes first. `rx_valid` pulses and `frame_err` does not.

## Test plan
- **Single command byte:** CS low, DC=0, byte 0xA5 at 5 MHz, CS high → exactly one `rx_valid` with `rx_data=0x0A5`; `frame_err` stays 0.
- **Window and pixel stream:**
  - Send 0x2A, 00 0A 00 0B, then 0x2B, 00 14 00 15, then 0x2C and 8 data bytes forming F800, 07E0, 001F, FFFF.
  - Required: 4 `pix_valid` pulses at (10,20), (11,20), (10,21), (11,21) carrying those colours.
  - A 5th pixel wraps to (10,20).
- **Truncated byte:** CS high after 5 bits → one `frame_err` and no `rx_valid`. The next full byte 0x3C (DC=1) gives `rx_data=0x13C`.
- **Partial CASET:** 0x2A, 00 05, then 0x2C and a pixel → the pixel lands at (0,0), window unchanged. Abort mid-RAMWR after the high byte with 0x00 → no `pix_valid`, FSM returns to IDLE.
- **RAMWR across CS frames:** RAMWR split across two CS frames, with the pixel high and low bytes in different frames → one pixel emitted, address continuity kept.
- **Reset:** assert `sys_rst` mid-byte and mid-RAMWR → all outputs 0 and window restored to (0..239, 0..319). A subsequent 0x2C plus a pixel → pixel at (0,0).
